mem_wb_skid_stage: RTL and testbench

- Parametrised successor of the MEM→WB pipeline register.
- Adds valid/ready flow control, a 2-entry skid buffer, synchronous flush, x0-write suppression, a write-back data mux and a saturating stall counter.
- Sits between the data-memory stage and the register-file write port.
- Lets WB back-pressure MEM without a combinational ready path.

---
 rtl/mem_wb_skid_stage.sv | 121 ++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with valid/ready flow control and a two-entry skid buffer.
// in_ready is decoded from registered state only, so WB back-pressure never reaches MEM combinationally.
module mem_wb_skid_stage #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned RD_W          = 5,
    parameter int unsigned ZERO_SUPPRESS = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mem_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mem_read_data,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic [DATA_W-1:0] mem_read_data;
        logic [DATA_W-1:0] alu_result;
        logic [RD_W-1:0]   rd;
        logic              reg_write;
        logic              mem_to_reg;
    } beat_t;

    // EMPTY: nothing held, ONE: main valid, FULL: main and skid valid.
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t state;
    beat_t  main_q;
    beat_t  skid_q;
    beat_t  in_beat;
    logic   acc;
    logic   pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: every field is assigned before the conditional override, so no latch is inferred.
    always_comb begin
        in_beat.mem_read_data = in_mem_read_data;
        in_beat.alu_result    = in_alu_result;
        in_beat.rd            = in_rd;
        in_beat.reg_write     = in_reg_write;
        in_beat.mem_to_reg    = in_mem_to_reg;
        if (ZERO_SUPPRESS != 0 && in_rd == '0) begin
            in_beat.reg_write = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            // NOTE: the payload registers are reset because their contents drive out_* directly and must read 0.
            main_q      <= '0;
            skid_q      <= '0;
            stall_count <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end

            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (acc) begin
                            main_q <= in_beat;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (acc && pop) begin
                            main_q <= in_beat;
                        end else if (acc) begin
                            skid_q <= in_beat;
                            state  <= FULL;
                        end else if (pop) begin
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            main_q <= skid_q;
                            state  <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign out_mem_read_data = main_q.mem_read_data;
    assign out_alu_result    = main_q.alu_result;
    assign out_rd            = main_q.rd;
    assign out_mem_to_reg    = main_q.mem_to_reg;
    assign out_reg_write     = main_q.reg_write && out_valid;
    assign out_wb_data       = main_q.mem_to_reg ? main_q.mem_read_data : main_q.alu_result;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: directed vector table, queue-based reference model under random
// traffic, and hand sequences for counter saturation and mid-transfer reset.
module tb_mem_wb_skid_stage;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int CNT_W  = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mem_read_data;
    logic [DATA_W-1:0] in_alu_result;
    logic [RD_W-1:0]   in_rd;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_mem_read_data;
    logic [DATA_W-1:0] out_alu_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_reg_write;
    logic              out_mem_to_reg;
    logic [DATA_W-1:0] out_wb_data;
    logic [CNT_W-1:0]  stall_count;

    mem_wb_skid_stage #(
        .DATA_W(DATA_W), .RD_W(RD_W), .ZERO_SUPPRESS(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_read_data(in_mem_read_data), .in_alu_result(in_alu_result),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mem_read_data(out_mem_read_data), .out_alu_result(out_alu_result),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_wb_data(out_wb_data), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: an ordered list of held beats (at most two) and a saturating stall tally.
    typedef struct {
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] alu;
        logic [RD_W-1:0]   rd;
        logic              rw;
        logic              m2r;
    } mbeat_t;

    mbeat_t mq[$];
    int     m_cnt = 0;

    task automatic model_step();
        bit     held_any = (mq.size() > 0);
        bit     room     = (mq.size() < 2);
        mbeat_t b;
        if (reset) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            if (held_any && !out_ready && !flush && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (held_any && out_ready) void'(mq.pop_front());
                if (in_valid && room) begin
                    b.mem = in_mem_read_data;
                    b.alu = in_alu_result;
                    b.rd  = in_rd;
                    b.rw  = (in_rd == 0) ? 1'b0 : in_reg_write;
                    b.m2r = in_mem_to_reg;
                    mq.push_back(b);
                end
            end
        end
    endtask

    task automatic check_model();
        bit v = (mq.size() > 0);
        check("m_out_valid", out_valid, v);
        check("m_in_ready", in_ready, mq.size() < 2);
        check("m_stall", stall_count, m_cnt);
        check("m_out_reg_write", out_reg_write, v ? mq[0].rw : 1'b0);
        if (v) begin
            check("m_out_rd", out_rd, mq[0].rd);
            check("m_out_mem", out_mem_read_data, mq[0].mem);
            check("m_out_alu", out_alu_result, mq[0].alu);
            check("m_out_m2r", out_mem_to_reg, mq[0].m2r);
            check("m_out_wb", out_wb_data, mq[0].m2r ? mq[0].mem : mq[0].alu);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_mem"}, out_mem_read_data, 0);
        check({tag, "_out_alu"}, out_alu_result, 0);
        check({tag, "_out_rd"}, out_rd, 0);
        check({tag, "_out_rw"}, out_reg_write, 0);
        check({tag, "_out_m2r"}, out_mem_to_reg, 0);
        check({tag, "_out_wb"}, out_wb_data, 0);
        check({tag, "_stall"}, stall_count, 0);
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are examined at the next falling edge.
    task automatic cycle(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic [DATA_W-1:0] mem, input logic [DATA_W-1:0] alu,
                         input logic [RD_W-1:0] rd, input logic rw, input logic m2r);
        reset            = rst;
        flush            = fl;
        in_valid         = iv;
        out_ready        = ordy;
        in_mem_read_data = mem;
        in_alu_result    = alu;
        in_rd            = rd;
        in_reg_write     = rw;
        in_mem_to_reg    = m2r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic              fl, iv, ordy;
        logic [DATA_W-1:0] mem, alu;
        logic [RD_W-1:0]   rd;
        logic              rw, m2r;
        logic              e_ov, e_ir;
        logic [DATA_W-1:0] e_wb;
        logic [RD_W-1:0]   e_rd;
        logic              e_rw;
        int                e_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic fl, input logic iv, input logic ordy,
                           input logic [DATA_W-1:0] mem, input logic [DATA_W-1:0] alu,
                           input logic [RD_W-1:0] rd, input logic rw, input logic m2r,
                           input logic e_ov, input logic e_ir, input logic [DATA_W-1:0] e_wb,
                           input logic [RD_W-1:0] e_rd, input logic e_rw, input int e_stall);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.mem = mem; v.alu = alu; v.rd = rd;
        v.rw = rw; v.m2r = m2r; v.e_ov = e_ov; v.e_ir = e_ir; v.e_wb = e_wb;
        v.e_rd = e_rd; v.e_rw = e_rw; v.e_stall = e_stall;
        vecs.push_back(v);
    endtask

    initial begin
        logic              r_iv, r_or, r_fl, r_rw, r_m2r;
        logic [RD_W-1:0]   r_rd;
        logic [DATA_W-1:0] r_mem, r_alu;

        // Single beat streams straight through.
        add_vec(0, 1, 1, 32'hDEADBEEF, 32'h10, 5, 1, 1,  1, 1, 32'hDEADBEEF, 5, 1, 0);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0,                  0, 1, 0, 0, 0, 0);
        // Back-pressure fills the skid entry, then drains A before B.
        add_vec(0, 1, 0, 0, 1, 1, 1, 0,                  1, 1, 1, 1, 1, 0);
        add_vec(0, 1, 0, 0, 2, 2, 1, 0,                  1, 0, 1, 1, 1, 1);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0,                  1, 0, 1, 1, 1, 2);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0,                  1, 1, 2, 2, 1, 2);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0,                  0, 1, 0, 0, 0, 2);
        // Eight back-to-back beats with accept and pop in the same cycle.
        for (int i = 0; i < 8; i++) begin
            add_vec(0, 1, 1, 32'hFFFF0000, i, 3, 1, 0,   1, 1, i, 3, 1, 2);
        end
        add_vec(0, 0, 1, 0, 0, 0, 0, 0,                  0, 1, 0, 0, 0, 2);
        // Fill with A and B, then flush while C is offered.
        add_vec(0, 1, 0, 0, 32'hA, 10, 1, 0,             1, 1, 32'hA, 10, 1, 2);
        add_vec(0, 1, 0, 0, 32'hB, 11, 1, 0,             1, 0, 32'hA, 10, 1, 3);
        add_vec(1, 1, 0, 0, 32'hC, 12, 1, 0,             0, 1, 0, 0, 0, 3);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0,                  0, 1, 0, 0, 0, 3);
        // Destination x0: reg_write suppressed, data kept.
        add_vec(0, 1, 0, 0, 32'h55, 0, 1, 0,             1, 1, 32'h55, 0, 0, 3);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0,                  0, 1, 0, 0, 0, 3);

        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_reset_state("rst");

        foreach (vecs[i]) begin
            cycle(0, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].mem, vecs[i].alu,
                  vecs[i].rd, vecs[i].rw, vecs[i].m2r);
            check($sformatf("tbl%0d_out_valid", i), out_valid, vecs[i].e_ov);
            check($sformatf("tbl%0d_in_ready", i), in_ready, vecs[i].e_ir);
            check($sformatf("tbl%0d_out_rw", i), out_reg_write, vecs[i].e_rw);
            check($sformatf("tbl%0d_stall", i), stall_count, vecs[i].e_stall);
            if (vecs[i].e_ov) begin
                check($sformatf("tbl%0d_out_wb", i), out_wb_data, vecs[i].e_wb);
                check($sformatf("tbl%0d_out_rd", i), out_rd, vecs[i].e_rd);
            end
            check_model();
        end

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            r_iv  = 1'($urandom_range(0, 3) != 0);
            r_or  = 1'($urandom_range(0, 2) != 0);
            r_fl  = 1'($urandom_range(0, 19) == 0);
            r_rd  = ($urandom_range(0, 3) == 0) ? '0 : RD_W'($urandom_range(1, 31));
            r_rw  = 1'($urandom_range(0, 1));
            r_m2r = 1'($urandom_range(0, 1));
            r_mem = $urandom;
            r_alu = $urandom;
            cycle(0, r_fl, r_iv, r_or, r_mem, r_alu, r_rd, r_rw, r_m2r);
            check_model();
        end

        // Stall counter saturation, then reset with a beat held and another offered.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_reset_state("rst2");
        cycle(0, 0, 1, 0, 32'h1234, 32'h77, 7, 1, 0);
        check("sat_load_valid", out_valid, 1);
        check("sat_load_stall", stall_count, 0);
        for (int j = 1; j <= 10; j++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
            check($sformatf("sat_stall_%0d", j), stall_count, (j < CNT_MAX) ? j : CNT_MAX);
        end
        cycle(1, 0, 1, 1, 32'h9999, 32'h8888, 9, 1, 1);
        check_reset_state("rst3");
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_out_rw", out_reg_write, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
